la_capture: RTL and testbench
=============================

Name: la_capture

Overview:
- Parametrised on-chip logic-analyser capture core for debug-probing internal nets such as the frame-buffer serial/column counters and shift clocks, without the vendor JTAG analyser.
- Stores DATA_W probe bits per sample into a DEPTH-entry ring buffer, qualified by a sample-enable strobe (e.g. a divider tap).
- Has a programmable pre-trigger window and a mask/value/edge trigger per channel.
- After capture, the host reads samples in chronological order.

Parameters:
- DATA_W, 14, probe channels per sample.
- DEPTH, 256, samples per capture; power of two, at least 4.
- ADDR_W, $clog2(DEPTH), index width; derived, not overridden.

Ports:
- clk_i  in  1  sole clock.
- rst_ni  in  1  asynchronous active-low reset.
- sample_en_i  in  1  sample strobe; data sampled only on cycles where high.
- data_i  in  DATA_W  probe inputs.
- arm_i  in  1  single-cycle pulse; starts a new capture.
- abort_i  in  1  single-cycle pulse; cancels the capture.
- trig_mask_i  in  DATA_W  1 = channel takes part in the trigger.
- trig_value_i  in  DATA_W  required level, or edge target level.
- trig_edge_i  in  DATA_W  1 = edge channel (transition to trig_value), 0 = level channel.
- pretrig_i  in  ADDR_W  samples kept before the trigger sample; sampled at arm.
- state_o  out  2  0 IDLE, 1 PRETRIG, 2 ARMED, 3 POST.
- done_o  out  1  capture complete, buffer valid.
- trig_addr_o  out  ADDR_W  physical address of the trigger sample.
- start_addr_o  out  ADDR_W  physical address of the oldest sample (trig_addr − pretrig, mod DEPTH).
- rd_en_i  in  1  read request.
- rd_idx_i  in  ADDR_W  chronological index; 0 = oldest sample.
- rd_data_o  out  DATA_W  read data.
- rd_valid_o  out  1  read data valid.

Behaviour:
- Reset values: state IDLE, done_o=0, trig_addr_o=0, start_addr_o=0, rd_data_o=0, rd_valid_o=0. Write pointer and counters are 0. Prev-sample register is 0. RAM is not reset.
- Prev-sample register loads data_i on every sample_en_i cycle, in every state.
- Trigger hit on a sample requires both:
  - Level channels: ((data ^ value) & mask & ~edge) == 0.
  - Edge channels: for every bit with mask & edge set, data != prev and data == value.
- mask = 0 hits on every sample.
- arm_i, from any state:
  - Latch pretrig_i into pre_q; write pointer = 0; count = 0; done_o = 0.
  - Next state is PRETRIG if pre_q > 0, else ARMED.
- Priority: abort_i beats arm_i in the same cycle. abort_i sends the block to IDLE with done_o = 0; trig_addr_o and start_addr_o hold.
- Writes occur in PRETRIG, ARMED and POST, on sample_en_i cycles only. mem[wp] = data_i, then wp increments mod DEPTH.
- PRETRIG:
  - Counts written samples; the trigger is ignored.
  - Moves to ARMED on the cycle the pre_q-th sample is written.
- ARMED:
  - Ring writes continue and wrap freely.
  - On a hit, the hit sample is written, trig_addr_o = wp, start_addr_o = wp − pre_q, and post count = DEPTH−1−pre_q.
  - Next state is POST if post count > 0. Otherwise go to IDLE with done_o = 1.
- POST:
  - Writes post count further samples.
  - On the last write, go to IDLE with done_o = 1 in the following cycle.
- Total samples stored = DEPTH, with the trigger sample at chronological index pre_q.
- Read port:
  - Accepted in any state. Physical address = start_addr_o + rd_idx_i (mod DEPTH).
  - rd_data_o and rd_valid_o are registered, 1-cycle latency; rd_valid_o = rd_en_i delayed by one cycle.
  - Data is undefined unless done_o = 1.
- Simultaneous read and write: the RAM is simple dual-port, read-before-write; no bypass.
- Reset asserted mid-capture returns all outputs to reset values immediately (asynchronous).

Decomposition:
- la_pkg holds:
  - state enum (IDLE/PRETRIG/ARMED/POST, 2-bit encoding as above);
  - localparam helpers for ADDR_W.
- Sub-module la_trigger holds the prev-sample register and the hit comparator. Its ports are clk_i, rst_ni, sample_en_i, data_i, mask, value, edge, and hit_o (combinational on the current sample).
- The RAM is inferred inside la_capture, coded so it maps to block RAM.

Test Plan:
- DEPTH=16, pretrig=4, mask=0x0001, value=1, level; data_i = ramp starting at 0, sample_en every 4th cycle; arm before the first sample -> trigger on data=5, trig_addr=5, start_addr=1, done_o rises after data=16 is written; reading idx 0..15 returns 1..16.
- Edge: mask=0x2000, edge=0x2000, value=0x2000, data bit13 held high from arm -> no trigger; bit13 driven low then high at sample 9 -> trigger at sample 9.
- pretrig=0, mask=0 -> state goes IDLE->ARMED->POST, trigger on the first sample, start_addr=0, 16 samples, reading idx 0..15 returns 0..15.
- Wrap: pretrig=4, mask=0x3FFF, value=30, ramp -> trig_addr=14, start_addr=10; idx0 reads 26, idx4 reads 30, idx15 reads 41.
- Abort pulse during POST -> IDLE, done_o=0. arm_i and abort_i in the same cycle -> IDLE. A later arm restarts a clean capture.
- sample_en_i low for 50 cycles while in ARMED with a matching value on data_i -> no write, no trigger. rst_ni pulsed low mid-POST -> all outputs return to reset values within the same cycle.

Source files
------------

// File: rtl/la_pkg.sv
// Shared types for the logic-analyser capture core: FSM state encoding and index-width helper.
// Pure declarations; no latency and no flow control.
package la_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRETRIG = 2'd1,
        ST_ARMED   = 2'd2,
        ST_POST    = 2'd3
    } la_state_e;

    function automatic int la_addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/la_trigger.sv
// Per-channel mask/value/edge trigger comparator with its previous-sample register.
// hit_o is combinational on the current sample; no backpressure, prev updates on every sample strobe.
module la_trigger #(
    parameter int DATA_W = 14
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              sample_en_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [DATA_W-1:0] mask,
    input  logic [DATA_W-1:0] value,
    input  logic [DATA_W-1:0] edge_en,
    output logic              hit_o
);

    logic [DATA_W-1:0] prev_q;
    logic [DATA_W-1:0] edge_bits;
    logic              value_ok;
    logic              edge_ok;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q <= '0;
        end else if (sample_en_i) begin
            prev_q <= data_i;
        end
    end

    // Edge channels must also sit at the target level, so one value compare covers both kinds.
    assign edge_bits = mask & edge_en;
    assign value_ok  = ((data_i ^ value) & mask) == '0;
    assign edge_ok   = ((data_i ^ prev_q) & edge_bits) == edge_bits;
    assign hit_o     = value_ok && edge_ok;

endmodule

// File: rtl/la_capture.sv
// Logic-analyser capture: pre-trigger ring buffer of DEPTH samples, chronological read-back.
// Read latency 1 cycle; no backpressure, samples are taken on every sample_en_i strobe while capturing.
module la_capture
    import la_pkg::*;
#(
    parameter int   DATA_W = 14,
    parameter int   DEPTH  = 256,
    localparam int  ADDR_W = la_addr_w(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              sample_en_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              arm_i,
    input  logic              abort_i,
    input  logic [DATA_W-1:0] trig_mask_i,
    input  logic [DATA_W-1:0] trig_value_i,
    input  logic [DATA_W-1:0] trig_edge_i,
    input  logic [ADDR_W-1:0] pretrig_i,
    output logic [1:0]        state_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] trig_addr_o,
    output logic [ADDR_W-1:0] start_addr_o,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_idx_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o
);

    la_state_e         state_q;
    logic [ADDR_W-1:0] wp_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] post_q;
    logic [ADDR_W-1:0] pre_q;
    logic              done_q;
    logic [ADDR_W-1:0] trig_addr_q;
    logic [ADDR_W-1:0] start_addr_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;

    logic              hit;
    logic              wr_en;
    logic [ADDR_W-1:0] cnt_nxt;
    logic [ADDR_W-1:0] post_init;
    logic [ADDR_W-1:0] rd_addr;

    logic [DATA_W-1:0] mem [DEPTH];

    la_trigger #(
        .DATA_W (DATA_W)
    ) u_trigger (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .sample_en_i (sample_en_i),
        .data_i      (data_i),
        .mask        (trig_mask_i),
        .value       (trig_value_i),
        .edge_en     (trig_edge_i),
        .hit_o       (hit)
    );

    // arm/abort take the cycle over, so no sample is stored on a control pulse.
    assign wr_en     = sample_en_i && (state_q != ST_IDLE) && !abort_i && !arm_i;
    assign cnt_nxt   = cnt_q + ADDR_W'(1);
    assign post_init = ADDR_W'(DEPTH - 1) - pre_q;
    assign rd_addr   = start_addr_q + rd_idx_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            wp_q         <= '0;
            cnt_q        <= '0;
            post_q       <= '0;
            pre_q        <= '0;
            done_q       <= 1'b0;
            trig_addr_q  <= '0;
            start_addr_q <= '0;
        end else if (abort_i) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
        end else if (arm_i) begin
            pre_q   <= pretrig_i;
            wp_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            state_q <= (pretrig_i != '0) ? ST_PRETRIG : ST_ARMED;
        end else if (wr_en) begin
            wp_q <= wp_q + ADDR_W'(1);
            case (state_q)
                ST_PRETRIG: begin
                    cnt_q <= cnt_nxt;
                    if (cnt_nxt == pre_q) begin
                        state_q <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (hit) begin
                        trig_addr_q  <= wp_q;
                        start_addr_q <= wp_q - pre_q;
                        post_q       <= post_init;
                        if (post_init != '0) begin
                            state_q <= ST_POST;
                        end else begin
                            state_q <= ST_IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_POST: begin
                    post_q <= post_q - ADDR_W'(1);
                    if (post_q == ADDR_W'(1)) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Sample storage: write port only, no reset, so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wp_q] <= data_i;
        end
    end

    // Read-before-write: a same-cycle write to rd_addr returns the old word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en_i;
            if (rd_en_i) begin
                rd_data_q <= mem[rd_addr];
            end
        end
    end

    assign state_o      = state_q;
    assign done_o       = done_q;
    assign trig_addr_o  = trig_addr_q;
    assign start_addr_o = start_addr_q;
    assign rd_data_o    = rd_data_q;
    assign rd_valid_o   = rd_valid_q;

endmodule

// File: tb/tb_la_capture.sv
// Bench for la_capture at DEPTH=16: vector table, hand-written corner sequences, random captures.
module tb_la_capture;

    localparam int DW    = 14;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          sample_en_i;
    logic [DW-1:0] data_i;
    logic          arm_i;
    logic          abort_i;
    logic [DW-1:0] trig_mask_i;
    logic [DW-1:0] trig_value_i;
    logic [DW-1:0] trig_edge_i;
    logic [AW-1:0] pretrig_i;
    logic [1:0]    state_o;
    logic          done_o;
    logic [AW-1:0] trig_addr_o;
    logic [AW-1:0] start_addr_o;
    logic          rd_en_i;
    logic [AW-1:0] rd_idx_i;
    logic [DW-1:0] rd_data_o;
    logic          rd_valid_o;

    always #5 clk_i = ~clk_i;

    la_capture #(
        .DATA_W (DW),
        .DEPTH  (DEPTH)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .sample_en_i  (sample_en_i),
        .data_i       (data_i),
        .arm_i        (arm_i),
        .abort_i      (abort_i),
        .trig_mask_i  (trig_mask_i),
        .trig_value_i (trig_value_i),
        .trig_edge_i  (trig_edge_i),
        .pretrig_i    (pretrig_i),
        .state_o      (state_o),
        .done_o       (done_o),
        .trig_addr_o  (trig_addr_o),
        .start_addr_o (start_addr_o),
        .rd_en_i      (rd_en_i),
        .rd_idx_i     (rd_idx_i),
        .rd_data_o    (rd_data_o),
        .rd_valid_o   (rd_valid_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the capture is the list of samples stored since arm;
    // the trigger is the first qualifying sample at list index >= pretrig.
    logic [DW-1:0] m_prev;
    logic [DW-1:0] m_samples [$];
    bit            m_active;
    bit            m_done;
    int            m_pre;
    int            m_trig;
    logic [AW-1:0] m_trig_addr;
    logic [AW-1:0] m_start_addr;

    typedef struct {
        int            pre;
        logic [DW-1:0] mask;
        logic [DW-1:0] value;
        logic [DW-1:0] edg;
        int            trig;
        int            start;
        int            first;
        int            last;
    } vec_t;

    vec_t vecs [6];

    function automatic bit model_hit(input logic [DW-1:0] d, input logic [DW-1:0] p,
                                     input logic [DW-1:0] mk, input logic [DW-1:0] vl,
                                     input logic [DW-1:0] ed);
        for (int i = 0; i < DW; i++) begin
            if (mk[i]) begin
                if (d[i] != vl[i]) return 1'b0;
                if (ed[i] && (d[i] == p[i])) return 1'b0;
            end
        end
        return 1'b1;
    endfunction

    function automatic logic [1:0] model_state();
        if (!m_active) return 2'd0;
        if (m_samples.size() < m_pre) return 2'd1;
        if (m_trig < 0) return 2'd2;
        return 2'd3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_prev       = '0;
        m_active     = 1'b0;
        m_done       = 1'b0;
        m_pre        = 0;
        m_trig       = -1;
        m_trig_addr  = '0;
        m_start_addr = '0;
        m_samples.delete();
    endtask

    // One clock: drive, let the edge happen, advance the model, check control outputs.
    task automatic cyc(input bit sen, input logic [DW-1:0] d, input bit arm, input bit abort);
        sample_en_i = sen;
        data_i      = d;
        arm_i       = arm;
        abort_i     = abort;
        @(posedge clk_i);
        if (abort) begin
            m_active = 1'b0;
            m_done   = 1'b0;
        end else if (arm) begin
            m_active = 1'b1;
            m_done   = 1'b0;
            m_samples.delete();
            m_trig   = -1;
            m_pre    = int'(pretrig_i);
        end else if (sen && m_active) begin
            m_samples.push_back(d);
            if (m_trig < 0 && m_samples.size() > m_pre &&
                model_hit(d, m_prev, trig_mask_i, trig_value_i, trig_edge_i)) begin
                m_trig       = m_samples.size() - 1;
                m_trig_addr  = AW'(m_trig);
                m_start_addr = AW'(m_trig - m_pre);
            end
            if (m_trig >= 0 && m_samples.size() == m_trig - m_pre + DEPTH) begin
                m_active = 1'b0;
                m_done   = 1'b1;
            end
        end
        if (sen) m_prev = d;
        #1;
        sample_en_i = 1'b0;
        arm_i       = 1'b0;
        abort_i     = 1'b0;
        check("state", state_o, model_state());
        check("done", done_o, m_done);
        check("trig_addr", trig_addr_o, m_trig_addr);
        check("start_addr", start_addr_o, m_start_addr);
    endtask

    task automatic arm_with(input int pre, input logic [DW-1:0] mk, input logic [DW-1:0] vl,
                            input logic [DW-1:0] ed);
        pretrig_i    = AW'(pre);
        trig_mask_i  = mk;
        trig_value_i = vl;
        trig_edge_i  = ed;
        cyc(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic read_one(input int idx, output logic [DW-1:0] d);
        rd_en_i  = 1'b1;
        rd_idx_i = AW'(idx);
        cyc(1'b0, '0, 1'b0, 1'b0);
        d = rd_data_o;
        rd_en_i = 1'b0;
    endtask

    task automatic read_all();
        for (int i = 0; i < DEPTH; i++) begin
            rd_en_i  = 1'b1;
            rd_idx_i = AW'(i);
            cyc(1'b0, '0, 1'b0, 1'b0);
            check("rd_valid", rd_valid_o, 1);
            if (m_done) check("rd_data", rd_data_o, m_samples[m_trig - m_pre + i]);
        end
        rd_en_i = 1'b0;
        cyc(1'b0, '0, 1'b0, 1'b0);
        check("rd_valid_low", rd_valid_o, 0);
    endtask

    // Ramp data held for 4 cycles, strobed on the last one, until done or budget runs out.
    task automatic run_ramp(input int start, input int budget);
        int v;
        v = start;
        for (int c = 0; c < budget; c++) begin
            cyc((c % 4) == 3, DW'(v), 1'b0, 1'b0);
            if ((c % 4) == 3) v++;
            if (m_done) break;
        end
        check("capture_done_in_budget", done_o, 1);
    endtask

    initial begin
        logic [DW-1:0] d;
        logic [DW-1:0] rdat;
        logic [DW-1:0] mk;

        vecs[0] = '{4,  14'h0001, 14'h0001, 14'h0000, 5,  1, 1,  16};
        vecs[1] = '{4,  14'h3FFF, 14'd30,   14'h0000, 14, 10, 26, 41};
        vecs[2] = '{0,  14'h0000, 14'h0000, 14'h0000, 0,  0, 0,  15};
        vecs[3] = '{15, 14'h3FFF, 14'd20,   14'h0000, 4,  5, 5,  20};
        vecs[4] = '{2,  14'h0003, 14'h0003, 14'h0000, 3,  1, 1,  16};
        vecs[5] = '{1,  14'h0004, 14'h0000, 14'h0004, 8,  7, 7,  22};

        rst_ni       = 1'b1;
        sample_en_i  = 1'b0;
        data_i       = '0;
        arm_i        = 1'b0;
        abort_i      = 1'b0;
        trig_mask_i  = '0;
        trig_value_i = '0;
        trig_edge_i  = '0;
        pretrig_i    = '0;
        rd_en_i      = 1'b0;
        rd_idx_i     = '0;
        model_reset();

        #2 rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_state", state_o, 0);
        check("rst_done", done_o, 0);
        check("rst_trig_addr", trig_addr_o, 0);
        check("rst_start_addr", start_addr_o, 0);
        check("rst_rd_data", rd_data_o, 0);
        check("rst_rd_valid", rd_valid_o, 0);
        rst_ni = 1'b1;
        cyc(1'b0, '0, 1'b0, 1'b0);

        // Table-driven ramp captures.
        for (int k = 0; k < 6; k++) begin
            arm_with(vecs[k].pre, vecs[k].mask, vecs[k].value, vecs[k].edg);
            run_ramp(0, 400);
            check("vec_trig_addr", trig_addr_o, vecs[k].trig);
            check("vec_start_addr", start_addr_o, vecs[k].start);
            read_one(0, rdat);
            check("vec_idx0", rdat, vecs[k].first);
            read_one(DEPTH - 1, rdat);
            check("vec_idx_last", rdat, vecs[k].last);
            read_all();
        end

        // Edge channel: bit13 held high gives no trigger; low then high fires.
        pretrig_i = '0;
        trig_mask_i = 14'h2000;
        trig_value_i = 14'h2000;
        trig_edge_i = 14'h2000;
        cyc(1'b1, 14'h2000, 1'b0, 1'b0);
        arm_with(0, 14'h2000, 14'h2000, 14'h2000);
        for (int s = 0; s < 10; s++) begin
            d = (s == 8) ? DW'(s) : (DW'(s) | 14'h2000);
            cyc(1'b1, d, 1'b0, 1'b0);
            if (s == 7) check("edge_held_no_trig", state_o, 2);
        end
        check("edge_trig_addr", trig_addr_o, 9);
        check("edge_state_post", state_o, 3);
        cyc(1'b1, 14'h0010, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1);
        check("abort_state", state_o, 0);
        check("abort_done", done_o, 0);
        check("abort_trig_hold", trig_addr_o, 9);

        // arm and abort together: abort wins.
        pretrig_i = 4'd3;
        cyc(1'b0, '0, 1'b1, 1'b1);
        check("arm_abort_state", state_o, 0);

        // Clean restart after abort.
        arm_with(0, 14'h0000, 14'h0000, 14'h0000);
        for (int s = 0; s < DEPTH; s++) cyc(1'b1, DW'(100 + s), 1'b0, 1'b0);
        check("restart_done", done_o, 1);
        for (int i = 0; i < DEPTH; i++) begin
            read_one(i, rdat);
            check("restart_rd", rdat, 100 + i);
        end

        // Matching data with no strobe must not write or trigger.
        arm_with(0, 14'h3FFF, 14'h0155, 14'h0000);
        for (int c = 0; c < 50; c++) cyc(1'b0, 14'h0155, 1'b0, 1'b0);
        check("no_strobe_armed", state_o, 2);
        cyc(1'b1, 14'h0155, 1'b0, 1'b0);
        check("strobe_trig_post", state_o, 3);
        for (int c = 0; c < 3; c++) cyc(1'b1, DW'(c), 1'b0, 1'b0);
        rd_en_i  = 1'b1;
        rd_idx_i = '0;
        cyc(1'b0, '0, 1'b0, 1'b0);
        check("pre_rst_rd_valid", rd_valid_o, 1);
        check("pre_rst_rd_data", rd_data_o, 14'h0155);
        rst_ni = 1'b0;
        #1;
        check("mid_rst_state", state_o, 0);
        check("mid_rst_done", done_o, 0);
        check("mid_rst_trig_addr", trig_addr_o, 0);
        check("mid_rst_start_addr", start_addr_o, 0);
        check("mid_rst_rd_data", rd_data_o, 0);
        check("mid_rst_rd_valid", rd_valid_o, 0);
        rd_en_i = 1'b0;
        model_reset();
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        cyc(1'b0, '0, 1'b0, 1'b0);

        // Randomised captures against the model.
        for (int r = 0; r < 8; r++) begin
            mk = DW'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) mk = mk | 14'h2000;
            arm_with($urandom_range(0, DEPTH - 1), mk, DW'($urandom) & mk, DW'($urandom) & mk);
            for (int c = 0; c < 400; c++) begin
                cyc($urandom_range(0, 1) == 1, DW'($urandom), 1'b0, 1'b0);
                if (m_done) break;
            end
            if (m_done) read_all();
            else cyc(1'b0, '0, 1'b0, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
        $fatal(1);
    end

endmodule
